// File: rtl/req_ext_pkg.sv
// Shared types for the multi-channel request stretcher.
package req_ext_pkg;

    typedef enum logic [1:0] {
        EXT_RETRIG,
        EXT_QUEUE,
        EXT_DROP
    } ext_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STRETCH,
        S_GAP
    } ext_state_e;

endpackage

// File: rtl/req_ext_channel.sv
// One stretcher channel: IDLE/STRETCH/GAP FSM with its counters, pending flag
// and registered status outputs.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | ext low, waiting for a request
//   S_STRETCH | ext high, cnt counts 1..LEN, ack ends early
//   S_GAP     | ext low for GAP_LEN cycles, pend/req restarts a stretch
module req_ext_channel
    import req_ext_pkg::*;
#(
    parameter int        LEN     = 21,
    parameter int        GAP_LEN = 1,
    parameter ext_mode_e MODE    = EXT_RETRIG
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ack,
    output logic ext,
    output logic done,
    output logic dropped,
    output logic busy
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam int GAP_W = $clog2(GAP_LEN + 1);

    ext_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gcnt;
    logic             pend;
    logic             req_prev;
    logic             new_req;

    // While stretching, only a fresh request (rising edge) counts as a
    // re-request; a held req then yields the LEN-high / GAP_LEN-low cadence.
    assign new_req = req & ~req_prev;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            gcnt     <= '0;
            pend     <= 1'b0;
            req_prev <= 1'b0;
            ext      <= 1'b0;
            done     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            req_prev <= req;
            done     <= 1'b0;
            dropped  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_STRETCH;
                        cnt   <= CNT_W'(1);
                        ext   <= 1'b1;
                    end
                end
                S_STRETCH: begin
                    if (ack) begin
                        state <= S_GAP;
                        cnt   <= '0;
                        gcnt  <= GAP_W'(1);
                        ext   <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        if (MODE == EXT_RETRIG && new_req) begin
                            cnt <= CNT_W'(1);
                        end else if (cnt == CNT_W'(LEN)) begin
                            state <= S_GAP;
                            cnt   <= '0;
                            gcnt  <= GAP_W'(1);
                            ext   <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (MODE == EXT_QUEUE && new_req) begin
                            if (pend) dropped <= 1'b1;
                            else      pend    <= 1'b1;
                        end
                        if (MODE == EXT_DROP && new_req) begin
                            dropped <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt == GAP_W'(GAP_LEN)) begin
                        gcnt <= '0;
                        pend <= 1'b0;
                        if (pend || req) begin
                            state <= S_STRETCH;
                            cnt   <= CNT_W'(1);
                            ext   <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        gcnt <= gcnt + GAP_W'(1);
                        if (req) pend <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    gcnt  <= '0;
                    pend  <= 1'b0;
                    ext   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/req_extension_mc.sv
// Multi-channel request stretcher: NUM_CH independent channels turning short
// req pulses into guaranteed-width ext levels with a guaranteed low gap.
module req_extension_mc
    import req_ext_pkg::*;
#(
    parameter int        NUM_CH  = 4,
    parameter int        LEN     = 21,
    parameter int        GAP_LEN = 1,
    parameter ext_mode_e MODE    = EXT_RETRIG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] ack_i,
    output logic [NUM_CH-1:0] ext_o,
    output logic [NUM_CH-1:0] done_o,
    output logic [NUM_CH-1:0] dropped_o,
    output logic              busy_o
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("req_extension_mc: NUM_CH must be >= 1");
    end
    if (LEN < 1) begin : g_bad_len
        $error("req_extension_mc: LEN must be >= 1");
    end
    if (GAP_LEN < 1) begin : g_bad_gap_len
        $error("req_extension_mc: GAP_LEN must be >= 1");
    end

    logic [NUM_CH-1:0] busy_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_ext_channel #(
            .LEN     (LEN),
            .GAP_LEN (GAP_LEN),
            .MODE    (MODE)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .req     (req_i[i]),
            .ack     (ack_i[i]),
            .ext     (ext_o[i]),
            .done    (done_o[i]),
            .dropped (dropped_o[i]),
            .busy    (busy_ch[i])
        );
    end

    assign busy_o = |busy_ch;

endmodule
